i2c_slave: RTL and testbench
============================

# i2c_slave

Memory-mapped I2C slave (target) peripheral on the rRISC 8-bit IO bus. It lets the CPU be addressed by an external I2C master: it detects START/STOP, matches a programmable 7-bit address, receives and transmits bytes, and ACKs/NACKs. It stretches SCL when the CPU has not yet read the previous byte or supplied the next one. It sits beside `i2c_master` on the same IO decode and open-drain pad structure.

## Interface
- `base_addr`, default 6'h20: IO address of register 0; registers occupy base..base+5.
- `sys_clk` in 1: system clock.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `io_a` in 6: IO address.
- `io_di` in 8: write data.
- `io_do` out 8: registered read data. 0 when no selected read.
- `io_re` / `io_we` in 1: read / write strobe, one cycle each.
- `i2c_irq` out 1: interrupt, equal to `irq_flag & ien`, registered.
- `scl_i`, `sda_i` in 1: bus line inputs.
- `scl_o`, `sda_o` out 1: constant 1'b0.
- `scl_oen_o`, `sda_oen_o` out 1: output enables, active low (0 drives the line low).

## Operation
- Registers, at offset from base:
  - +0 SADR[6:0]: own address, R/W, reset 0.
  - +1 CTR: [7] en, [6] ien; R/W, reset 0.
  - +2 TXR: write loads the byte and clears txe; reads return the last value written.
  - +3 RXR: read returns the byte and clears rxf.
  - +4 SR, read-only: [7] rw (1 = master reads), [6] addressed, [5] stop seen, [3] master NACK, [2] txe, [1] rxf, [0] irq_flag. Other bits read 0.
  - +5 CMD, write-only: [0] = 1 clears irq_flag and the stop bit; [1] nack_next: NACK the next received data byte (self-clears after use).
- Input conditioning:
  - `scl_i` and `sda_i` pass through a 2-flop synchronizer, then a 3-sample majority filter.
  - Edge detection runs on the filtered values.
- Bus events:
  - START/repeated START: SDA falls while SCL is high. From any state, go to ADDR with bit count 0.
  - STOP: SDA rises while SCL is high. Go to IDLE; if addressed, set the stop bit and irq_flag.
- FSM states: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, STRETCH_RX, STRETCH_TX.
  - ADDR: shift SDA in on SCL rising, MSB first, 8 bits.
    - On SCL fall after bit 8: if en=1 and [7:1] == SADR, set addressed, latch rw, go to ADDR_ACK and drive SDA low.
    - Otherwise go to IDLE and ignore traffic until the next START.
  - ADDR_ACK: on SCL fall, release SDA.
    - rw=0 → RX.
    - rw=1 → TX if txe=0, else STRETCH_TX.
  - RX: shift 8 bits.
    - On SCL fall after bit 8: if rxf=1 → STRETCH_RX (hold scl_oen_o=0).
    - Otherwise copy the shifter to RXR, set rxf and irq_flag, drive ACK (SDA low, or released if nack_next), go to RX_ACK.
  - STRETCH_RX: on an RXR read, do the same transfer as above and release SCL on the next cycle.
  - RX_ACK: on SCL fall, release SDA, go to RX.
  - TX: load the shifter from TXR, set txe and irq_flag.
    - Drive each bit on SDA (released = 1) after SCL fall; MSB appears right after entering TX.
    - On SCL fall after bit 8, release SDA → TX_ACK.
  - TX_ACK: sample SDA on SCL rising.
    - ACK → on SCL fall go to TX, or STRETCH_TX if txe=1.
    - NACK → set the master-NACK bit and irq_flag, go to IDLE (released) until STOP/START.
  - STRETCH_TX: hold SCL low until TXR is written, then go to TX.
- Disabling: en=0 forces IDLE, releases both lines, and clears addressed.
- Precedence:
  - A write to CMD[0] in the same cycle as a new irq event leaves irq_flag=1.
  - A bus START or STOP aborts stretching and releases SCL immediately.

## Timing
- Reset values: `io_do`=0, `i2c_irq`=0, `scl_oen_o`=1, `sda_oen_o`=1, FSM=IDLE, txe=1, rxf=0, all registers 0.
- A reset during a transfer releases both lines asynchronously.
- Input latency is 2 sync + 2 filter cycles, so a bus edge acts 4–5 `sys_clk` cycles later. The design requires `sys_clk` ≥ 20× SCL frequency.
- `io_do` is valid on the cycle after `io_re`. The RXR read clear takes effect on that same edge.
- `i2c_irq` lags `irq_flag` by 1 cycle.
- A stretch ends no more than 2 cycles after the releasing IO access.

## Test plan
- SADR=0x42, en=1, master writes 0x84 then 0x5A, STOP → ACK on address and data, RXR=0x5A, SR shows rxf=1 and stop=1, `i2c_irq`=1 only when ien=1.
- Address 0x43 (address 0x21) while SADR=0x42 → no ACK, SDA never driven, SR.addressed=0.
- Master writes 2 bytes with no RXR read → SCL held low after the 2nd byte. Reading RXR (0x11) → SCL released within 2 cycles, second RXR read = 0x22.
- Master reads (0x85) with TXR=0xC3 preloaded → bus shows 0xC3. txe=1 → stretch until TXR=0x3C is written, then 0x3C. Master NACK → SR[3]=1, lines released.
- Repeated START mid-RX, and en cleared mid-TX → FSM restarts at ADDR / goes to IDLE, both oen outputs = 1.
- `sys_rst` asserted during a stretch → `scl_oen_o`=1 with no clock edge required.

Source files
------------

// File: rtl/i2c_slave_if.sv
// IO bus and I2C pad signals of the i2c_slave peripheral.
// The master modport is the CPU/bus side; the slave modport is the peripheral.
interface i2c_slave_if;
    logic [5:0] io_a;
    logic [7:0] io_di;
    logic [7:0] io_do;
    logic       io_re;
    logic       io_we;
    logic       i2c_irq;
    logic       scl_i;
    logic       sda_i;
    logic       scl_o;
    logic       sda_o;
    logic       scl_oen_o;
    logic       sda_oen_o;

    modport master (
        output io_a, io_di, io_re, io_we, scl_i, sda_i,
        input  io_do, i2c_irq, scl_o, sda_o, scl_oen_o, sda_oen_o
    );

    modport slave (
        input  io_a, io_di, io_re, io_we, scl_i, sda_i,
        output io_do, i2c_irq, scl_o, sda_o, scl_oen_o, sda_oen_o
    );
endinterface

// File: rtl/i2c_slave.sv
// Memory-mapped I2C target: address match, byte RX/TX, ACK/NACK and SCL stretching
// while the CPU has not consumed or supplied a byte.
module i2c_slave #(
    parameter logic [5:0] base_addr = 6'h20
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    i2c_slave_if.slave bus
);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_ADDR       = 4'd1;
    localparam logic [3:0] S_ADDR_ACK   = 4'd2;
    localparam logic [3:0] S_RX         = 4'd3;
    localparam logic [3:0] S_RX_ACK     = 4'd4;
    localparam logic [3:0] S_TX         = 4'd5;
    localparam logic [3:0] S_TX_ACK     = 4'd6;
    localparam logic [3:0] S_STRETCH_RX = 4'd7;
    localparam logic [3:0] S_STRETCH_TX = 4'd8;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    logic [1:0] scl_sync, sda_sync, scl_hist, sda_hist;
    logic       scl_f, sda_f, scl_q, sda_q;
    logic [3:0] state, bit_cnt;
    logic [7:0] shifter, txr, rxr, sr;
    logic [6:0] sadr;
    logic       en, ien, txe, rxf, rw, addressed, stop_seen, mnack, irq_flag, nack_next, tx_load;
    logic [5:0] off;
    logic       hit, rd, wr, rxr_rd, rx_commit;
    logic       scl_rise, scl_fall, start_det, stop_det;

    assign bus.scl_o = 1'b0;
    assign bus.sda_o = 1'b0;

    assign off       = bus.io_a - base_addr;
    assign hit       = off < 6'd6;
    assign rd        = bus.io_re & hit;
    assign wr        = bus.io_we & hit;
    assign rxr_rd    = rd & (off == 6'd3);
    assign sr        = {rw, addressed, stop_seen, 1'b0, mnack, txe, rxf, irq_flag};

    assign scl_rise  = scl_f & ~scl_q;
    assign scl_fall  = ~scl_f & scl_q;
    assign start_det = scl_f & scl_q & sda_q & ~sda_f;
    assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;

    // A full byte is handed to RXR either straight away or once a stretched RX is released by a read
    assign rx_commit = ((state == S_RX) & scl_fall & (bit_cnt == 4'd8) & ~rxf)
                     | ((state == S_STRETCH_RX) & rxr_rd);

    // Input stage: 2-flop synchronizer, then 3-sample majority vote
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_f    <= 1'b1;
            sda_f    <= 1'b1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.scl_i};
            sda_sync <= {sda_sync[0], bus.sda_i};
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_f    <= maj3({scl_sync[1], scl_hist});
            sda_f    <= maj3({sda_sync[1], sda_hist});
            scl_q    <= scl_f;
            sda_q    <= sda_f;
        end
    end

    // Register file and protocol FSM; FSM updates come last so bus events win over CPU clears
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.io_do     <= '0;
            bus.i2c_irq   <= 1'b0;
            bus.scl_oen_o <= 1'b1;
            bus.sda_oen_o <= 1'b1;
            state         <= S_IDLE;
            bit_cnt       <= '0;
            shifter       <= '0;
            txr           <= '0;
            rxr           <= '0;
            sadr          <= '0;
            en            <= 1'b0;
            ien           <= 1'b0;
            txe           <= 1'b1;
            rxf           <= 1'b0;
            rw            <= 1'b0;
            addressed     <= 1'b0;
            stop_seen     <= 1'b0;
            mnack         <= 1'b0;
            irq_flag      <= 1'b0;
            nack_next     <= 1'b0;
            tx_load       <= 1'b0;
        end else begin
            bus.io_do <= '0;
            if (rd) begin
                case (off)
                    6'd0:    bus.io_do <= {1'b0, sadr};
                    6'd1:    bus.io_do <= {en, ien, 6'b0};
                    6'd2:    bus.io_do <= txr;
                    6'd3:    bus.io_do <= rxr;
                    6'd4:    bus.io_do <= sr;
                    default: bus.io_do <= '0;
                endcase
            end
            if (rxr_rd)
                rxf <= 1'b0;
            if (wr) begin
                case (off)
                    6'd0: sadr <= bus.io_di[6:0];
                    6'd1: begin
                        en  <= bus.io_di[7];
                        ien <= bus.io_di[6];
                    end
                    6'd2: begin
                        txr <= bus.io_di;
                        txe <= 1'b0;
                    end
                    6'd5: begin
                        if (bus.io_di[0]) begin
                            irq_flag  <= 1'b0;
                            stop_seen <= 1'b0;
                        end
                        if (bus.io_di[1])
                            nack_next <= 1'b1;
                    end
                    default: ;
                endcase
            end
            bus.i2c_irq <= irq_flag & ien;

            if (!en) begin
                state         <= S_IDLE;
                bus.scl_oen_o <= 1'b1;
                bus.sda_oen_o <= 1'b1;
                addressed     <= 1'b0;
                tx_load       <= 1'b0;
            end else if (start_det) begin
                state         <= S_ADDR;
                bit_cnt       <= '0;
                bus.scl_oen_o <= 1'b1;
                bus.sda_oen_o <= 1'b1;
                addressed     <= 1'b0;
                tx_load       <= 1'b0;
            end else if (stop_det) begin
                state         <= S_IDLE;
                bus.scl_oen_o <= 1'b1;
                bus.sda_oen_o <= 1'b1;
                tx_load       <= 1'b0;
                if (addressed) begin
                    stop_seen <= 1'b1;
                    irq_flag  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: ;
                    S_ADDR: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shifter[7:1] == sadr) begin
                                addressed     <= 1'b1;
                                rw            <= shifter[0];
                                bus.sda_oen_o <= 1'b0;
                                state         <= S_ADDR_ACK;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bus.sda_oen_o <= 1'b1;
                            bit_cnt       <= '0;
                            if (!rw) begin
                                state <= S_RX;
                            end else if (!txe) begin
                                state   <= S_TX;
                                tx_load <= 1'b1;
                            end else begin
                                state         <= S_STRETCH_TX;
                                bus.scl_oen_o <= 1'b0;
                            end
                        end
                    end
                    S_RX: begin
                        if (scl_rise) begin
                            shifter <= {shifter[6:0], sda_f};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8 && rxf) begin
                            state         <= S_STRETCH_RX;
                            bus.scl_oen_o <= 1'b0;
                        end
                    end
                    S_RX_ACK: begin
                        if (scl_fall) begin
                            bus.sda_oen_o <= 1'b1;
                            bit_cnt       <= '0;
                            state         <= S_RX;
                        end
                    end
                    S_TX: begin
                        if (tx_load) begin
                            shifter       <= txr;
                            bus.sda_oen_o <= txr[7];
                            bus.scl_oen_o <= 1'b1;
                            txe           <= 1'b1;
                            irq_flag      <= 1'b1;
                            tx_load       <= 1'b0;
                        end else if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                bus.sda_oen_o <= 1'b1;
                                state         <= S_TX_ACK;
                            end else begin
                                shifter       <= {shifter[6:0], 1'b1};
                                bus.sda_oen_o <= shifter[6];
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (scl_rise && sda_f) begin
                            mnack    <= 1'b1;
                            irq_flag <= 1'b1;
                            state    <= S_IDLE;
                        end else if (scl_fall) begin
                            bit_cnt <= '0;
                            if (txe) begin
                                state         <= S_STRETCH_TX;
                                bus.scl_oen_o <= 1'b0;
                            end else begin
                                state   <= S_TX;
                                tx_load <= 1'b1;
                            end
                        end
                    end
                    S_STRETCH_RX: ;
                    S_STRETCH_TX: begin
                        if (!txe) begin
                            state   <= S_TX;
                            tx_load <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
                if (rx_commit) begin
                    rxr           <= shifter;
                    rxf           <= 1'b1;
                    irq_flag      <= 1'b1;
                    bus.sda_oen_o <= nack_next;
                    nack_next     <= 1'b0;
                    bus.scl_oen_o <= 1'b1;
                    state         <= S_RX_ACK;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged I2C master on wired-AND lines plus CPU register accesses.
module tb_i2c_slave;
    localparam int Q = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_slave_if bus();
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    assign bus.scl_i = scl_m & bus.scl_oen_o;
    assign bus.sda_i = sda_m & bus.sda_oen_o;

    i2c_slave #(.base_addr(6'h20)) dut (
        .sys_clk(clk),
        .sys_rst(rst),
        .bus    (bus.slave)
    );

    int n_chk = 0;
    int n_err = 0;

    logic mon_en = 1'b0;
    logic sda_drv;
    always @(posedge clk) begin
        if (!mon_en)
            sda_drv <= 1'b0;
        else if (!bus.sda_oen_o)
            sda_drv <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_wr(input logic [5:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.io_a  = a;
        bus.io_di = d;
        bus.io_we = 1'b1;
        @(posedge clk);
        #1;
        bus.io_we = 1'b0;
    endtask

    task automatic io_rd(input logic [5:0] a, output logic [7:0] d);
        @(posedge clk);
        #1;
        bus.io_a  = a;
        bus.io_re = 1'b1;
        @(posedge clk);
        #1;
        bus.io_re = 1'b0;
        d = bus.io_do;
    endtask

    task automatic scl_wait();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (bus.scl_i) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!ok)
            chk("scl_timeout", 32'(ok), 32'd1);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        scl_wait();
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(2 * Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        scl_wait();
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        scl_wait();
        wait_clk(2 * Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        scl_wait();
        wait_clk(Q);
        b = bus.sda_i;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--)
            write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(ack);
    endtask

    logic [7:0] rdat;
    logic [7:0] byte_d;
    logic       ack;
    logic       b;
    logic [2:0] bits;

    initial begin
        bus.io_a  = '0;
        bus.io_di = '0;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        #1 rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);

        chk("rst_io_do", 32'(bus.io_do), 32'h0);
        chk("rst_irq", 32'(bus.i2c_irq), 32'h0);
        chk("rst_scl_oen", 32'(bus.scl_oen_o), 32'h1);
        chk("rst_sda_oen", 32'(bus.sda_oen_o), 32'h1);
        io_rd(6'h24, rdat);
        chk("rst_sr", 32'(rdat), 32'h04);

        // Master write 0x84 / 0x5A to own address 0x42
        io_wr(6'h20, 8'h42);
        io_wr(6'h21, 8'h80);
        io_rd(6'h20, rdat);
        chk("sadr_rd", 32'(rdat), 32'h42);
        start_c();
        write_byte(8'h84, ack);
        chk("wr_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h5A, ack);
        chk("wr_data_ack", 32'(ack), 32'h0);
        stop_c();
        io_rd(6'h24, rdat);
        chk("wr_sr", 32'(rdat), 32'h67);
        chk("irq_masked", 32'(bus.i2c_irq), 32'h0);
        io_wr(6'h21, 8'hC0);
        wait_clk(2);
        chk("irq_enabled", 32'(bus.i2c_irq), 32'h1);
        io_rd(6'h23, rdat);
        chk("wr_rxr", 32'(rdat), 32'h5A);
        io_wr(6'h25, 8'h01);
        wait_clk(2);
        chk("irq_cleared", 32'(bus.i2c_irq), 32'h0);
        io_rd(6'h24, rdat);
        chk("sr_after_clr", 32'(rdat), 32'h44);

        // Foreign address 0x21 must be ignored
        mon_en = 1'b1;
        start_c();
        write_byte(8'h43, ack);
        chk("foreign_nack", 32'(ack), 32'h1);
        stop_c();
        wait_clk(2);
        chk("foreign_sda_idle", 32'(sda_drv), 32'h0);
        mon_en = 1'b0;
        io_rd(6'h24, rdat);
        chk("foreign_sr", 32'(rdat), 32'h04);

        // Two bytes without reading RXR: stretch after the second
        start_c();
        write_byte(8'h84, ack);
        chk("rxs_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h11, ack);
        chk("rxs_d1_ack", 32'(ack), 32'h0);
        byte_d = 8'h22;
        for (int i = 7; i >= 0; i--)
            write_bit(byte_d[i]);
        wait_clk(10);
        chk("rx_stretch_hold", 32'(bus.scl_oen_o), 32'h0);
        io_rd(6'h23, rdat);
        chk("rx_stretch_rxr1", 32'(rdat), 32'h11);
        wait_clk(1);
        chk("rx_stretch_release", 32'(bus.scl_oen_o), 32'h1);
        read_bit(ack);
        chk("rxs_d2_ack", 32'(ack), 32'h0);
        stop_c();
        io_rd(6'h23, rdat);
        chk("rx_stretch_rxr2", 32'(rdat), 32'h22);

        // Master read: preloaded 0xC3, then stretch until 0x3C is written, then NACK
        io_wr(6'h22, 8'hC3);
        io_wr(6'h25, 8'h01);
        start_c();
        write_byte(8'h85, ack);
        chk("rd_addr_ack", 32'(ack), 32'h0);
        read_byte(byte_d, 1'b0);
        chk("rd_byte1", 32'(byte_d), 32'hC3);
        wait_clk(10);
        chk("tx_stretch_hold", 32'(bus.scl_oen_o), 32'h0);
        io_rd(6'h24, rdat);
        chk("tx_stretch_sr", 32'(rdat), 32'hC5);
        io_wr(6'h22, 8'h3C);
        wait_clk(2);
        chk("tx_stretch_release", 32'(bus.scl_oen_o), 32'h1);
        read_byte(byte_d, 1'b1);
        chk("rd_byte2", 32'(byte_d), 32'h3C);
        wait_clk(4);
        chk("nack_sda_rel", 32'(bus.sda_oen_o), 32'h1);
        chk("nack_scl_rel", 32'(bus.scl_oen_o), 32'h1);
        io_rd(6'h24, rdat);
        chk("nack_sr", 32'(rdat), 32'hCD);
        stop_c();
        io_rd(6'h24, rdat);
        chk("nack_stop_sr", 32'(rdat), 32'hED);

        // Repeated START in the middle of a received byte
        start_c();
        write_byte(8'h84, ack);
        chk("rs_addr_ack", 32'(ack), 32'h0);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        start_c();
        chk("rs_scl_oen", 32'(bus.scl_oen_o), 32'h1);
        chk("rs_sda_oen", 32'(bus.sda_oen_o), 32'h1);
        write_byte(8'h84, ack);
        chk("rs_readdr_ack", 32'(ack), 32'h0);
        write_byte(8'h77, ack);
        chk("rs_data_ack", 32'(ack), 32'h0);
        stop_c();
        io_rd(6'h23, rdat);
        chk("rs_rxr", 32'(rdat), 32'h77);

        // Disable in the middle of a transmitted byte
        io_wr(6'h22, 8'hA5);
        start_c();
        write_byte(8'h85, ack);
        chk("dis_addr_ack", 32'(ack), 32'h0);
        for (int i = 2; i >= 0; i--) begin
            read_bit(b);
            bits[i] = b;
        end
        chk("dis_bits", 32'(bits), 32'h5);
        wait_clk(3);
        chk("dis_tx_drive", 32'(bus.sda_oen_o), 32'h0);
        io_wr(6'h21, 8'h00);
        wait_clk(2);
        chk("dis_sda_rel", 32'(bus.sda_oen_o), 32'h1);
        chk("dis_scl_rel", 32'(bus.scl_oen_o), 32'h1);
        io_rd(6'h24, rdat);
        chk("dis_addressed", 32'(rdat[6]), 32'h0);
        stop_c();
        io_wr(6'h21, 8'h80);

        // Asynchronous reset while stretching on TX
        start_c();
        write_byte(8'h85, ack);
        chk("rst_addr_ack", 32'(ack), 32'h0);
        wait_clk(10);
        chk("rst_pre_stretch", 32'(bus.scl_oen_o), 32'h0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_async_scl", 32'(bus.scl_oen_o), 32'h1);
        chk("rst_async_sda", 32'(bus.sda_oen_o), 32'h1);
        wait_clk(2);
        rst = 1'b0;
        stop_c();
        io_rd(6'h24, rdat);
        chk("rst_final_sr", 32'(rdat), 32'h04);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
